apb_master_arbiter: RTL

- Shares one APB master port between NB_REQ requesters. The requesters are the core data port and the debug/DMA path, and each uses a req/gnt/rvalid handshake.
- The APB output feeds the peripheral bus slave port, which decodes to UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC control, debug and cipher.
- Arbitration is round-robin. The block sequences APB SETUP and ACCESS phases, one transfer at a time.

---
 rtl/apb_arb_pkg.sv | 16 +
 rtl/apb_master_arbiter_if.sv | 24 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/apb_master_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared state type, default timeout and index-width helper for the APB master arbiter
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_arb_state_e;

    localparam int APB_ARB_TIMEOUT_DEFAULT = 255;

    function automatic int rr_idx_width(input int nb_req);
        return (nb_req > 1) ? $clog2(nb_req) : 1;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - APB bus bundle between the arbiter (master) and the peripheral slave port
interface apb_master_arbiter_if #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    logic [APB_ADDR_WIDTH-1:0] paddr_o;
    logic [APB_DATA_WIDTH-1:0] pwdata_o;
    logic                      pwrite_o;
    logic                      psel_o;
    logic                      penable_o;
    logic [APB_DATA_WIDTH-1:0] prdata_i;
    logic                      pready_i;
    logic                      pslverr_i;

    modport master (
        output paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport slave (
        input  paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
        output prdata_i, pready_i, pslverr_i
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request above last_q, wrapping
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NB_REQ = 2,
    parameter int IDX_W  = rr_idx_width(NB_REQ)
) (
    input  logic [NB_REQ-1:0] req,
    input  logic [IDX_W-1:0]  last_q,
    output logic [IDX_W-1:0]  winner,
    output logic [NB_REQ-1:0] gnt,
    output logic              valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NB_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NB_REQ);
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
        gnt = valid ? (NB_REQ'(1) << winner) : '0;
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin sharing of one APB master port between NB_REQ requesters
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES without pready.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NB_REQ         = 2,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = APB_ARB_TIMEOUT_DEFAULT
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NB_REQ-1:0]                       req_i,
    input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]   addr_i,
    input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]   wdata_i,
    input  logic [NB_REQ-1:0]                       we_i,
    output logic [NB_REQ-1:0]                       gnt_o,
    output logic [NB_REQ-1:0]                       rvalid_o,
    output logic [APB_DATA_WIDTH-1:0]               rdata_o,
    output logic                                    err_o,
    apb_master_arbiter_if.master                    apb
);

    localparam int IDX_W = rr_idx_width(NB_REQ);

    if (NB_REQ < 2 || NB_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_master_arbiter: unsupported NB_REQ or TIMEOUT_CYCLES");
    end

    apb_arb_state_e    state_q, state_d;
    logic [IDX_W-1:0]  last_q, owner_q, arb_winner;
    logic [NB_REQ-1:0] arb_gnt;
    logic              arb_valid, done, abort, tmo_hit;

    rr_arbiter #(.NB_REQ(NB_REQ), .IDX_W(IDX_W)) u_rr (
        .req    (req_i),
        .last_q (last_q),
        .winner (arb_winner),
        .gnt    (arb_gnt),
        .valid  (arb_valid)
    );

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] tmo_cnt_q;

    // The cycle whose increment would reach TIMEOUT_CYCLES is the one that aborts.
    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q == SETUP) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ACCESS && !apb.pready_i) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        gnt_o         = '0;
        apb.psel_o    = 1'b0;
        apb.penable_o = 1'b0;
        done          = 1'b0;
        abort         = 1'b0;
        case (state_q)
            IDLE: begin
                // A grant during reset would be discarded, so it is not shown.
                if (arb_valid && !rst_i) begin
                    gnt_o   = arb_gnt;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                apb.psel_o = 1'b1;
                state_d    = ACCESS;
            end
            ACCESS: begin
                apb.psel_o    = 1'b1;
                apb.penable_o = 1'b1;
                if (apb.pready_i) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_q       <= IDX_W'(NB_REQ - 1);
            owner_q      <= '0;
            apb.paddr_o  <= '0;
            apb.pwdata_o <= '0;
            apb.pwrite_o <= 1'b0;
            rdata_o      <= '0;
            err_o        <= 1'b0;
            rvalid_o     <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_o <= '0;
            if (state_q == IDLE && arb_valid) begin
                owner_q      <= arb_winner;
                last_q       <= arb_winner;
                apb.paddr_o  <= addr_i[arb_winner];
                apb.pwdata_o <= wdata_i[arb_winner];
                apb.pwrite_o <= we_i[arb_winner];
            end
            if (done || abort) begin
                rvalid_o <= NB_REQ'(1) << owner_q;
                rdata_o  <= done ? apb.prdata_i : '0;
                err_o    <= done ? apb.pslverr_i : 1'b1;
            end
        end
    end

endmodule
